// File: rtl/cache_pkg.sv
// Types and constants shared between the data cache and its write-back buffer.
// Entry layout, drain FSM states and word-offset width live here so both sides agree.
package cache_pkg;

    localparam int WB_ADDR_WIDTH    = 32;
    localparam int WB_DATA_WIDTH    = 32;
    localparam int WORD_OFFSET_BITS = 2;

    typedef struct packed {
        logic                     valid;
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        WB_IDLE,
        WB_WRITE
    } wb_state_t;

endpackage

// File: rtl/write_back_buffer.sv
// Write-back buffer: queues evicted dirty words, drains them in order over a req/ack port,
// coalesces repeat words and forwards the youngest buffered copy to refill lookups.
module write_back_buffer
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_enable,
    input  logic [ADDR_WIDTH-1:0] wb_address,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_ready,
    output logic                  overflow_err,
    input  logic [ADDR_WIDTH-1:0] lookup_address,
    output logic                  lookup_hit,
    output logic [DATA_WIDTH-1:0] lookup_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    wb_entry_t             r_entries [DEPTH];
    ptr_t                  r_rd_ptr;
    ptr_t                  r_wr_ptr;
    logic [PTR_W:0]        r_count;
    wb_state_t             r_state;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_overflow_err;

    logic [PTR_W:0]        w_push_match;
    logic [PTR_W:0]        w_lookup_match;
    logic                  w_coalesce;
    ptr_t                  w_coalesce_idx;
    logic                  w_push;
    logic                  w_push_new;
    logic                  w_push_coalesce;
    logic                  w_ack;

    // Valid entries sit contiguously from rd_ptr, so walking oldest to youngest
    // and keeping the last hit yields the youngest match. Returns {hit, index}.
    function automatic logic [PTR_W:0] find_youngest(
        input wb_entry_t             ents [DEPTH],
        input ptr_t                  rd_ptr,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  skip_head
    );
        logic [PTR_W:0] res;
        ptr_t           idx;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + ptr_t'(k);
            if (ents[idx].valid && !(skip_head && k == 0) &&
                ents[idx].addr[ADDR_WIDTH-1:WORD_OFFSET_BITS] == addr[ADDR_WIDTH-1:WORD_OFFSET_BITS])
                res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        w_push_match    = find_youngest(r_entries, r_rd_ptr, wb_address, r_state == WB_WRITE);
        w_lookup_match  = find_youngest(r_entries, r_rd_ptr, lookup_address, 1'b0);
        w_coalesce      = w_push_match[PTR_W];
        w_coalesce_idx  = w_push_match[PTR_W-1:0];
        w_push          = wb_enable && wb_ready;
        w_push_new      = w_push && !w_coalesce;
        w_push_coalesce = w_push && w_coalesce;
        w_ack           = (r_state == WB_WRITE) && mem_ack;
    end

    assign wb_ready     = (r_count != FULL_COUNT);
    assign overflow_err = r_overflow_err;
    assign lookup_hit   = w_lookup_match[PTR_W];
    assign lookup_data  = lookup_hit ? r_entries[w_lookup_match[PTR_W-1:0]].data : '0;
    assign mem_we       = r_mem_we;
    assign mem_address  = r_mem_address;
    assign mem_wdata    = r_mem_wdata;
    assign empty        = (r_count == '0) && (r_state == WB_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_entries[i] <= '0;
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_count        <= '0;
            r_state        <= WB_IDLE;
            r_mem_we       <= 1'b0;
            r_mem_address  <= '0;
            r_mem_wdata    <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            if (wb_enable && !wb_ready)
                r_overflow_err <= 1'b1;
            if (w_push_coalesce)
                r_entries[w_coalesce_idx].data <= wb_data;
            if (w_push_new) begin
                r_entries[r_wr_ptr] <= '{valid: 1'b1, addr: wb_address, data: wb_data};
                r_wr_ptr            <= r_wr_ptr + ptr_t'(1);
            end
            if (w_ack) begin
                r_entries[r_rd_ptr].valid <= 1'b0;
                r_rd_ptr                  <= r_rd_ptr + ptr_t'(1);
            end
            r_count <= r_count + (PTR_W+1)'(w_push_new) - (PTR_W+1)'(w_ack);

            case (r_state)
                WB_IDLE: begin
                    if (r_count != '0) begin
                        r_state       <= WB_WRITE;
                        r_mem_we      <= 1'b1;
                        r_mem_address <= r_entries[r_rd_ptr].addr;
                        // A coalesce into the head in this same cycle must reach memory.
                        r_mem_wdata   <= (w_push_coalesce && w_coalesce_idx == r_rd_ptr) ?
                                         wb_data : r_entries[r_rd_ptr].data;
                    end
                end
                WB_WRITE: begin
                    if (mem_ack) begin
                        r_state  <= WB_IDLE;
                        r_mem_we <= 1'b0;
                    end
                end
                default: r_state <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_back_buffer.sv
// Directed bench for write_back_buffer: a memory responder with programmable ack latency
// logs every accepted write; each scenario task compares outputs against hand-computed values.
module tb_write_back_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_enable = 1'b0;
    logic [31:0] wb_address = '0;
    logic [31:0] wb_data = '0;
    logic        wb_ready;
    logic        overflow_err;
    logic [31:0] lookup_address = '0;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        empty;

    int vecs = 0;
    int errs = 0;

    bit ack_en  = 1'b0;
    int ack_lat = 1;
    int wcnt    = 0;
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];

    write_back_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .wb_enable(wb_enable), .wb_address(wb_address), .wb_data(wb_data),
        .wb_ready(wb_ready), .overflow_err(overflow_err),
        .lookup_address(lookup_address), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .mem_we(mem_we), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .empty(empty)
    );

    always #5 clk = ~clk;

    // Memory model: pulses mem_ack on the ack_lat-th cycle mem_we is seen high.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (ack_en && mem_we && !rst) begin
                wcnt++;
                if (wcnt >= ack_lat) begin
                    mem_ack = 1'b1;
                    log_a.push_back(mem_address);
                    log_d.push_back(mem_wdata);
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        wb_enable  = 1'b1;
        wb_address = a;
        wb_data    = d;
        tick();
        wb_enable  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // which: 0 = mem_we, 1 = empty, 2 = wb_ready
    task automatic wait_for(input int which, input string nm, input int bound);
        int n = 0;
        logic c;
        c = (which == 0) ? mem_we : (which == 1) ? empty : wb_ready;
        while (!c && n < bound) begin
            tick();
            n++;
            c = (which == 0) ? mem_we : (which == 1) ? empty : wb_ready;
        end
        vecs++;
        if (!c) begin
            $display("FAIL %s: timed out after %0d cycles, got 0, required 1", nm, bound);
            errs++;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        vecs++; if (wb_ready !== 1'b1)     begin $display("FAIL rst_ready: got %b required 1", wb_ready); errs++; end
        vecs++; if (overflow_err !== 1'b0) begin $display("FAIL rst_ovf: got %b required 0", overflow_err); errs++; end
        vecs++; if (mem_we !== 1'b0)       begin $display("FAIL rst_we: got %b required 0", mem_we); errs++; end
        vecs++; if (mem_address !== 32'h0) begin $display("FAIL rst_addr: got %h required 0", mem_address); errs++; end
        vecs++; if (mem_wdata !== 32'h0)   begin $display("FAIL rst_wdata: got %h required 0", mem_wdata); errs++; end
        vecs++; if (empty !== 1'b1)        begin $display("FAIL rst_empty: got %b required 1", empty); errs++; end
        vecs++; if (lookup_hit !== 1'b0)   begin $display("FAIL rst_hit: got %b required 0", lookup_hit); errs++; end
        vecs++; if (lookup_data !== 32'h0) begin $display("FAIL rst_ldata: got %h required 0", lookup_data); errs++; end
        tick();
        tick();
        rst = 1'b0;
        tick();
        // Reset in the middle of a write with two entries buffered.
        ack_en = 1'b0;
        push(32'h100, 32'h1);
        push(32'h104, 32'h2);
        wait_for(0, "rst_mid_we_rise", 10);
        lookup_address = 32'h100;
        rst = 1'b1;
        #1;
        vecs++; if (mem_we !== 1'b0)       begin $display("FAIL rstmid_we: got %b required 0", mem_we); errs++; end
        vecs++; if (empty !== 1'b1)        begin $display("FAIL rstmid_empty: got %b required 1", empty); errs++; end
        vecs++; if (wb_ready !== 1'b1)     begin $display("FAIL rstmid_ready: got %b required 1", wb_ready); errs++; end
        vecs++; if (overflow_err !== 1'b0) begin $display("FAIL rstmid_ovf: got %b required 0", overflow_err); errs++; end
        vecs++; if (lookup_hit !== 1'b0)   begin $display("FAIL rstmid_hit: got %b required 0", lookup_hit); errs++; end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_drain();
        int n = 0;
        log_a.delete(); log_d.delete();
        ack_en = 1'b1; ack_lat = 3;
        push(32'h0000_0040, 32'hDEAD_BEEF);
        wait_for(0, "drain_we_rise", 10);
        while (mem_we && n < 20) begin
            vecs++; if (mem_address !== 32'h40) begin $display("FAIL drain_addr: got %h required 00000040", mem_address); errs++; end
            vecs++; if (mem_wdata !== 32'hDEAD_BEEF) begin $display("FAIL drain_data: got %h required deadbeef", mem_wdata); errs++; end
            tick();
            n++;
        end
        vecs++; if (n != 3)          begin $display("FAIL drain_hold: got %0d cycles required 3", n); errs++; end
        vecs++; if (empty !== 1'b1)  begin $display("FAIL drain_empty: got %b required 1", empty); errs++; end
        vecs++; if (log_a.size() != 1) begin $display("FAIL drain_nwrites: got %0d required 1", log_a.size()); errs++; end
        else begin
            vecs++; if (log_d[0] !== 32'hDEAD_BEEF) begin $display("FAIL drain_mem: got %h required deadbeef", log_d[0]); errs++; end
        end
        ack_en = 1'b0;
    endtask

    task automatic test_fill_overflow();
        logic [31:0] ea[4];
        log_a.delete(); log_d.delete();
        ea = '{32'h10, 32'h20, 32'h30, 32'h40};
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) push(ea[i], 32'hF000 + 32'(i));
        vecs++; if (wb_ready !== 1'b0)     begin $display("FAIL full_ready: got %b required 0", wb_ready); errs++; end
        vecs++; if (overflow_err !== 1'b0) begin $display("FAIL full_ovf_pre: got %b required 0", overflow_err); errs++; end
        push(32'h50, 32'hF004);
        lookup_address = 32'h50;
        #1;
        vecs++; if (overflow_err !== 1'b1) begin $display("FAIL full_ovf: got %b required 1", overflow_err); errs++; end
        vecs++; if (lookup_hit !== 1'b0)   begin $display("FAIL full_drop_hit: got %b required 0", lookup_hit); errs++; end
        lookup_address = 32'h30;
        #1;
        vecs++; if (lookup_hit !== 1'b1 || lookup_data !== 32'hF002)
            begin $display("FAIL full_lookup: got %b/%h required 1/0000f002", lookup_hit, lookup_data); errs++; end
        ack_en = 1'b1; ack_lat = 1;
        tick();
        wait_for(1, "full_drain", 60);
        vecs++; if (log_a.size() != 4) begin $display("FAIL full_nwrites: got %0d required 4", log_a.size()); errs++; end
        for (int i = 0; i < 4 && i < log_a.size(); i++) begin
            vecs++;
            if (log_a[i] !== ea[i] || log_d[i] !== 32'hF000 + 32'(i))
                begin $display("FAIL full_order[%0d]: got %h/%h required %h/%h", i, log_a[i], log_d[i], ea[i], 32'hF000 + 32'(i)); errs++; end
        end
        vecs++; if (overflow_err !== 1'b1) begin $display("FAIL full_ovf_sticky: got %b required 1", overflow_err); errs++; end
        ack_en = 1'b0;
        do_reset();
        vecs++; if (overflow_err !== 1'b0) begin $display("FAIL full_ovf_clear: got %b required 0", overflow_err); errs++; end
    endtask

    task automatic test_coalesce();
        logic [31:0] ea[4];
        logic [31:0] ed[4];
        log_a.delete(); log_d.delete();
        ea = '{32'h20, 32'h30, 32'h40, 32'h50};
        ed = '{32'h1111, 32'h3333, 32'h4444, 32'h5555};
        ack_en = 1'b0;
        push(32'h20, 32'h1111);
        wait_for(0, "coal_we_rise", 10);
        push(32'h30, 32'h2222);
        push(32'h30, 32'h3333);
        lookup_address = 32'h30;
        #1;
        vecs++; if (lookup_hit !== 1'b1 || lookup_data !== 32'h3333)
            begin $display("FAIL coal_lookup: got %b/%h required 1/00003333", lookup_hit, lookup_data); errs++; end
        vecs++; if (mem_wdata !== 32'h1111) begin $display("FAIL coal_head: got %h required 00001111", mem_wdata); errs++; end
        // Two more distinct words fill exactly four slots only if 0x30 took one.
        push(32'h40, 32'h4444);
        vecs++; if (wb_ready !== 1'b1) begin $display("FAIL coal_count3: got ready %b required 1", wb_ready); errs++; end
        push(32'h50, 32'h5555);
        vecs++; if (wb_ready !== 1'b0) begin $display("FAIL coal_count4: got ready %b required 0", wb_ready); errs++; end
        vecs++; if (overflow_err !== 1'b0) begin $display("FAIL coal_ovf: got %b required 0", overflow_err); errs++; end
        ack_en = 1'b1; ack_lat = 2;
        wait_for(1, "coal_drain", 60);
        vecs++; if (log_a.size() != 4) begin $display("FAIL coal_nwrites: got %0d required 4", log_a.size()); errs++; end
        for (int i = 0; i < 4 && i < log_a.size(); i++) begin
            vecs++;
            if (log_a[i] !== ea[i] || log_d[i] !== ed[i])
                begin $display("FAIL coal_order[%0d]: got %h/%h required %h/%h", i, log_a[i], log_d[i], ea[i], ed[i]); errs++; end
        end
        ack_en = 1'b0;
    endtask

    task automatic test_no_coalesce_head();
        log_a.delete(); log_d.delete();
        ack_en = 1'b0;
        push(32'h20, 32'hAAAA);
        wait_for(0, "head_we_rise", 10);
        vecs++; if (mem_address !== 32'h20) begin $display("FAIL head_addr: got %h required 00000020", mem_address); errs++; end
        push(32'h20, 32'hBBBB);
        lookup_address = 32'h20;
        #1;
        vecs++; if (lookup_hit !== 1'b1 || lookup_data !== 32'hBBBB)
            begin $display("FAIL head_lookup: got %b/%h required 1/0000bbbb", lookup_hit, lookup_data); errs++; end
        vecs++; if (mem_wdata !== 32'hAAAA) begin $display("FAIL head_stable: got %h required 0000aaaa", mem_wdata); errs++; end
        ack_en = 1'b1; ack_lat = 1;
        wait_for(1, "head_drain", 40);
        vecs++; if (log_a.size() != 2) begin $display("FAIL head_nwrites: got %0d required 2", log_a.size()); errs++; end
        else begin
            vecs++; if (log_a[0] !== 32'h20 || log_d[0] !== 32'hAAAA)
                begin $display("FAIL head_w0: got %h/%h required 00000020/0000aaaa", log_a[0], log_d[0]); errs++; end
            vecs++; if (log_a[1] !== 32'h20 || log_d[1] !== 32'hBBBB)
                begin $display("FAIL head_w1: got %h/%h required 00000020/0000bbbb", log_a[1], log_d[1]); errs++; end
        end
        ack_en = 1'b0;
    endtask

    task automatic test_wrap_forward();
        logic [31:0] ea[3];
        logic [31:0] ed[3];
        log_a.delete(); log_d.delete();
        ack_en = 1'b1; ack_lat = 2;
        for (int i = 0; i < 10; i++) begin
            wait_for(2, "wrap_ready", 20);
            push(32'h200 + 32'(4 * i), 32'hC000 + 32'(i));
        end
        wait_for(1, "wrap_drain", 100);
        vecs++; if (log_a.size() != 10) begin $display("FAIL wrap_nwrites: got %0d required 10", log_a.size()); errs++; end
        for (int i = 0; i < 10 && i < log_a.size(); i++) begin
            vecs++;
            if (log_a[i] !== 32'h200 + 32'(4 * i) || log_d[i] !== 32'hC000 + 32'(i))
                begin $display("FAIL wrap_order[%0d]: got %h/%h required %h/%h", i, log_a[i], log_d[i], 32'h200 + 32'(4 * i), 32'hC000 + 32'(i)); errs++; end
        end
        lookup_address = 32'h200;
        #1;
        vecs++; if (lookup_hit !== 1'b0 || lookup_data !== 32'h0)
            begin $display("FAIL wrap_drained: got %b/%h required 0/00000000", lookup_hit, lookup_data); errs++; end
        tick();
        log_a.delete(); log_d.delete();
        ack_en = 1'b0;
        push(32'h300, 32'h1);
        push(32'h304, 32'h2);
        push(32'h300, 32'h3);
        lookup_address = 32'h300;
        #1;
        vecs++; if (lookup_hit !== 1'b1 || lookup_data !== 32'h3)
            begin $display("FAIL fwd_young: got %b/%h required 1/00000003", lookup_hit, lookup_data); errs++; end
        lookup_address = 32'h302;
        #1;
        vecs++; if (lookup_hit !== 1'b1 || lookup_data !== 32'h3)
            begin $display("FAIL fwd_byteoff: got %b/%h required 1/00000003", lookup_hit, lookup_data); errs++; end
        lookup_address = 32'h304;
        #1;
        vecs++; if (lookup_hit !== 1'b1 || lookup_data !== 32'h2)
            begin $display("FAIL fwd_304: got %b/%h required 1/00000002", lookup_hit, lookup_data); errs++; end
        lookup_address = 32'h308;
        #1;
        vecs++; if (lookup_hit !== 1'b0 || lookup_data !== 32'h0)
            begin $display("FAIL fwd_miss: got %b/%h required 0/00000000", lookup_hit, lookup_data); errs++; end
        ea = '{32'h300, 32'h304, 32'h300};
        ed = '{32'h1, 32'h2, 32'h3};
        ack_en = 1'b1; ack_lat = 1;
        tick();
        wait_for(1, "fwd_drain", 40);
        vecs++; if (log_a.size() != 3) begin $display("FAIL fwd_nwrites: got %0d required 3", log_a.size()); errs++; end
        for (int i = 0; i < 3 && i < log_a.size(); i++) begin
            vecs++;
            if (log_a[i] !== ea[i] || log_d[i] !== ed[i])
                begin $display("FAIL fwd_order[%0d]: got %h/%h required %h/%h", i, log_a[i], log_d[i], ea[i], ed[i]); errs++; end
        end
        ack_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_drain();
        test_fill_overflow();
        test_coalesce();
        test_no_coalesce_head();
        test_wrap_forward();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
